// File: rtl/wave_display_pkg.sv
// Shared constants, the stage-1 pipeline record and a span helper for wave_display.
package wave_display_pkg;

  localparam logic [23:0] WAVE_COLOR = 24'h00FF00;
  localparam logic [23:0] GRID_COLOR = 24'h404040;
  localparam int WINDOW_W = 512;
  localparam int SAMPLE_W = 8;
  localparam int ADDR_W   = 9;

  typedef struct packed {
    logic                valid;
    logic                in_win;
    logic                first;
    logic [ADDR_W-1:0]   addr;
    logic [SAMPLE_W-1:0] row;
    logic                grid;
  } stage_t;

  // Inclusive unsigned test: v lies between a and b in either order.
  function automatic logic in_span(input logic [SAMPLE_W-1:0] a,
                                   input logic [SAMPLE_W-1:0] b,
                                   input logic [SAMPLE_W-1:0] v);
    logic [SAMPLE_W-1:0] lo;
    logic [SAMPLE_W-1:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/wave_display_dffr.sv
// Reset-to-zero D flip-flop of parameterised width, synchronous active-high reset.
module dffr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/wave_display.sv
// Draws a 512-column waveform from sample RAM into the upper half of the frame.
// Define WAVE_DISPLAY_GRID_EN to overlay a 64-pixel grid behind the trace.
module wave_display
  import wave_display_pkg::*;
#(
  parameter logic [10:0] X_START = 11'd256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         x,
  input  logic [9:0]          y,
  input  logic                valid,
  input  logic                read_index,
  output logic [ADDR_W-1:0]   read_address,
  input  logic [SAMPLE_W-1:0] read_value,
  output logic                valid_pixel,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  output logic                wave_display_idle
);

`ifdef WAVE_DISPLAY_GRID_EN
  localparam logic GRID_ON = 1'b1;
`else
  localparam logic GRID_ON = 1'b0;
`endif

  logic [10:0]         x_rel;
  logic                live;
  logic                in_win;
  logic                line_start;
  logic                rd_half_q;
  logic                rd_half_d;
  logic [ADDR_W-1:0]   addr_q;
  stage_t              s0;
  stage_t              s1;
  logic [SAMPLE_W-1:0] cur_q;
  logic [SAMPLE_W-1:0] prev_q;
  logic [SAMPLE_W-1:0] cur_d;
  logic [SAMPLE_W-1:0] prev_d;
  logic [ADDR_W-1:0]   last_q;
  logic [ADDR_W-1:0]   last_d;
  logic                draw;
  logic [23:0]         pix_d;
  logic [23:0]         pix_q;
  logic                idle_d;

  assign x_rel      = x - X_START;
  assign live       = valid && !reset;
  assign in_win     = live && (x >= X_START) && (x_rel < 11'(WINDOW_W)) && !y[9];
  assign line_start = live && (x == X_START);

  // The RAM half is chosen once per line so a capture swap mid-line cannot tear the trace.
  assign rd_half_d    = line_start ? read_index : rd_half_q;
  assign read_address = in_win ? {rd_half_d, x_rel[8:1]} : addr_q;

  assign s0.valid  = valid;
  assign s0.in_win = in_win;
  assign s0.first  = (x_rel == 11'd0);
  assign s0.addr   = read_address;
  assign s0.row    = y[8:1];
  assign s0.grid   = GRID_ON && ((x_rel[5:0] == 6'd0) || (y[5:0] == 6'd0));
  assign idle_d    = valid && y[9];

  dffr #(.WIDTH(1))             u_rd_half (.clk(clk), .reset(reset), .d(rd_half_d), .q(rd_half_q));
  dffr #(.WIDTH(ADDR_W))        u_addr    (.clk(clk), .reset(reset), .d(read_address), .q(addr_q));
  dffr #(.WIDTH($bits(stage_t))) u_stage1 (.clk(clk), .reset(reset), .d(s0), .q(s1));
  dffr #(.WIDTH(1))             u_idle    (.clk(clk), .reset(reset), .d(idle_d), .q(wave_display_idle));

  // Track the two samples bounding the current column pair; a line restart reloads both
  // so the previous line's tail cannot draw a vertical spike at the left edge.
  always_comb begin
    cur_d  = cur_q;
    prev_d = prev_q;
    last_d = last_q;
    if (s1.in_win) begin
      last_d = s1.addr;
      if (s1.first) begin
        cur_d  = read_value;
        prev_d = read_value;
      end else if (s1.addr != last_q) begin
        prev_d = cur_q;
        cur_d  = read_value;
      end
    end
  end

  assign draw = s1.in_win && in_span(prev_d, cur_d, s1.row);

  always_comb begin
    pix_d = 24'h000000;
    if (draw)                      pix_d = WAVE_COLOR;
    else if (s1.in_win && s1.grid) pix_d = GRID_COLOR;
  end

  dffr #(.WIDTH(SAMPLE_W)) u_cur  (.clk(clk), .reset(reset), .d(cur_d),  .q(cur_q));
  dffr #(.WIDTH(SAMPLE_W)) u_prev (.clk(clk), .reset(reset), .d(prev_d), .q(prev_q));
  dffr #(.WIDTH(ADDR_W))   u_last (.clk(clk), .reset(reset), .d(last_d), .q(last_q));
  dffr #(.WIDTH(24))       u_pix  (.clk(clk), .reset(reset), .d(pix_d),  .q(pix_q));
  dffr #(.WIDTH(1))        u_vpix (.clk(clk), .reset(reset), .d(s1.valid), .q(valid_pixel));

  assign {r, g, b} = pix_q;

endmodule

// File: tb/tb_wave_display.sv
// Directed bench for wave_display: vector table streamed one pixel per cycle plus reset sequences.
module tb_wave_display;
  import wave_display_pkg::*;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        ri;
    logic        chk_addr;
    logic [8:0]  exp_addr;
    logic        chk_pix;
    logic [23:0] exp_rgb;
    logic        exp_vp;
    logic        exp_idle;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [10:0] x;
  logic [9:0] y;
  logic       valid;
  logic       read_index;
  logic [8:0] read_address;
  logic [7:0] read_value;
  logic       valid_pixel;
  logic [7:0] r, g, b;
  logic       wave_display_idle;

  logic [7:0] ram [0:511];
  vec_t       vecs[$];
  int         n_checks = 0;
  int         n_fail = 0;

  wave_display #(.X_START(11'd256)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .read_index(read_index),
    .read_address(read_address), .read_value(read_value), .valid_pixel(valid_pixel),
    .r(r), .g(g), .b(b), .wave_display_idle(wave_display_idle)
  );

  always #5 clk = ~clk;

  // Synchronous sample RAM: data follows the address by one cycle.
  always @(posedge clk) read_value <= ram[read_address];

  function automatic logic [23:0] bg(input int xr, input logic [9:0] yy);
    logic [10:0] xv;
    logic        hit;
    logic        on;
    xv  = 11'(xr);
    hit = (xv[5:0] == 6'd0) || (yy[5:0] == 6'd0);
`ifdef WAVE_DISPLAY_GRID_EN
    on = 1'b1;
`else
    on = 1'b0;
`endif
    return (on && hit) ? GRID_COLOR : 24'h000000;
  endfunction

  function automatic void add_vec(input int xx, input int yy, input bit v, input bit ri,
                                  input bit ca, input int ea, input bit cp, input logic [23:0] erg);
    vec_t t;
    t.x = 11'(xx);
    t.y = 10'(yy);
    t.valid = v;
    t.ri = ri;
    t.chk_addr = ca;
    t.exp_addr = 9'(ea);
    t.chk_pix = cp;
    t.exp_rgb = erg;
    t.exp_vp = v;
    t.exp_idle = v && t.y[9];
    vecs.push_back(t);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int xx, input int yy, input bit v, input bit ri);
    x = 11'(xx);
    y = 10'(yy);
    valid = v;
    read_index = ri;
  endtask

  // Stream the table: address checked in the same cycle, idle one cycle later, pixel two later.
  task automatic apply_stimulus();
    int n;
    n = vecs.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2 && vecs[k-2].chk_pix) begin
        check_output($sformatf("rgb[%0d]", k-2), {8'h0, r, g, b}, {8'h0, vecs[k-2].exp_rgb});
        check_output($sformatf("valid_pixel[%0d]", k-2), {31'h0, valid_pixel}, {31'h0, vecs[k-2].exp_vp});
      end
      if (k >= 1)
        check_output($sformatf("idle[%0d]", k-1), {31'h0, wave_display_idle}, {31'h0, vecs[k-1].exp_idle});
      if (k < n) drive(vecs[k].x, vecs[k].y, vecs[k].valid, vecs[k].ri);
      else       drive(0, 0, 1'b0, 1'b0);
      #1;
      if (k < n && vecs[k].chk_addr)
        check_output($sformatf("read_address[%0d]", k), {23'h0, read_address}, {23'h0, vecs[k].exp_addr});
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = (i < 256) ? 8'd64 : 8'd0;
    ram[9'h105] = 8'd100;
    ram[9'h106] = 8'd110;

    // Line on half 1 at y=0: address ramp 0x100..0x1FF, trace everywhere except the 100..110 step.
    for (int i = 0; i < 512; i++)
      add_vec(256 + i, 0, 1, 1, 1, 9'h100 | (i >> 1), 1,
              (i == 12 || i == 13) ? bg(i, 10'd0) : WAVE_COLOR);
    // y=210 (row 105) lies inside the 100..110 step and the falling edge after it.
    for (int i = 0; i < 16; i++)
      add_vec(256 + i, 210, 1, 1, 1, 9'h100 | (i >> 1), 1,
              (i >= 12) ? WAVE_COLOR : bg(i, 10'd210));
    // y=222 (row 111) is above every span.
    for (int i = 0; i < 16; i++)
      add_vec(256 + i, 222, 1, 1, 1, 9'h100 | (i >> 1), 1, bg(i, 10'd222));
    // y=10 (row 5) away from the step: no trace, grid only at x_rel 64.
    for (int i = 0; i < 71; i++)
      add_vec(256 + i, 10, 1, 1, 1, 9'h100 | (i >> 1), i >= 60, bg(i, 10'd10));
    // Left of the window: black, address holds.
    add_vec(255, 128, 1, 0, 1, 9'h123, 1, 24'h000000);
    // Flat half 0 at row 64: every column drawn; read_index flips at x=400 without effect.
    for (int i = 0; i < 512; i++)
      add_vec(256 + i, 128, 1, (256 + i) >= 400, 1, i >> 1, 1, WAVE_COLOR);
    add_vec(768, 128, 1, 1, 1, 9'h0FF, 1, 24'h000000);
    // Next line picks up half 1 (all zeros): no spike from the flat line's 64.
    for (int i = 0; i < 4; i++)
      add_vec(256 + i, 128, 1, 1, 1, 9'h100 | (i >> 1), 1, bg(i, 10'd128));
    add_vec(260, 128, 0, 1, 1, 9'h101, 1, 24'h000000);
    add_vec(300, 600, 1, 1, 1, 9'h101, 1, 24'h000000);
    add_vec(300, 600, 0, 1, 1, 9'h101, 1, 24'h000000);

    reset = 1'b1;
    drive(0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_output("reset read_address", {23'h0, read_address}, 32'h0);
    check_output("reset rgb", {8'h0, r, g, b}, 32'h0);
    check_output("reset valid_pixel", {31'h0, valid_pixel}, 32'h0);
    check_output("reset idle", {31'h0, wave_display_idle}, 32'h0);
    reset = 1'b0;

    // Single pixel: valid_pixel must rise exactly two cycles later.
    @(negedge clk); drive(256, 128, 1'b1, 1'b0);
    @(negedge clk); check_output("latency vp+1", {31'h0, valid_pixel}, 32'h0); drive(0, 0, 1'b0, 1'b0);
    @(negedge clk); check_output("latency vp+2", {31'h0, valid_pixel}, 32'h1);
    check_output("latency rgb+2", {8'h0, r, g, b}, {8'h0, WAVE_COLOR});
    @(negedge clk); check_output("latency vp+3", {31'h0, valid_pixel}, 32'h0);

    apply_stimulus();

    // Reset in the middle of a line discards everything in flight.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(256 + i, 128, 1'b1, 1'b0);
    end
    @(negedge clk); drive(260, 128, 1'b1, 1'b0); reset = 1'b1;
    @(negedge clk);
    check_output("midreset read_address", {23'h0, read_address}, 32'h0);
    check_output("midreset rgb", {8'h0, r, g, b}, 32'h0);
    check_output("midreset valid_pixel", {31'h0, valid_pixel}, 32'h0);
    check_output("midreset idle", {31'h0, wave_display_idle}, 32'h0);
    reset = 1'b0; drive(0, 0, 1'b0, 1'b0);
    @(negedge clk); check_output("post-reset vp idle", {31'h0, valid_pixel}, 32'h0); drive(261, 128, 1'b1, 1'b0);
    @(negedge clk); check_output("post-reset vp+1", {31'h0, valid_pixel}, 32'h0); drive(0, 0, 1'b0, 1'b0);
    @(negedge clk); check_output("post-reset vp+2", {31'h0, valid_pixel}, 32'h1);
    check_output("post-reset rgb+2", {8'h0, r, g, b}, {8'h0, WAVE_COLOR});
    @(negedge clk); check_output("post-reset vp+3", {31'h0, valid_pixel}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
